// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the reduced RISC-V core: fetch handshake, decode,
// ALU/memory sequencing, branch resolution from the ALU inequality flag, retire counting.
module multicycle_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  input  logic                  EQ,
  input  logic                  mem_ack,
  output logic                  instr_req,
  output logic                  IRwrite,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  ResultSrc,
  output logic                  RegWrite,
  output logic                  PCwrite,
  output logic                  PCsrc,
  output logic                  illegal,
  output logic [DATA_WIDTH-1:0] instret
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLT = 3'b010;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;
  localparam logic [F3_W-1:0] F3_W32 = 3'b010;
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT
  } state_t;

  // Only the decode fields of the instruction are kept; operands live in the datapath IR.
  typedef struct packed {
    logic              f7b5;
    logic [F3_W-1:0]   funct3;
    logic [OPC_W-1:0]  opcode;
  } ir_t;

  state_t     state, state_n;
  ir_t        ir_q;
  logic       legal_c, is_load_c, is_store_c, is_branch_c;
  logic [2:0] alu_op_c;
  logic       alu_src_c;
  logic [1:0] imm_src_c;
  logic       set_illegal_c, retire_c;
  logic       unused_instr;

  assign unused_instr = ^instr;

  function automatic logic [2:0] f3_to_alu(input logic [F3_W-1:0] f3, input logic sub);
    case (f3)
      F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
      F3_AND:  return ALU_AND;
      F3_OR:   return ALU_OR;
      F3_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Instruction decode from the latched IR fields
  always_comb begin
    legal_c   = 1'b0;
    alu_op_c  = ALU_ADD;
    alu_src_c = 1'b1;
    imm_src_c = IMM_I;
    case (ir_q.opcode)
      OPC_OP: begin
        legal_c   = ir_q.funct3 inside {F3_ADD, F3_AND, F3_OR, F3_SLT};
        alu_op_c  = f3_to_alu(ir_q.funct3, ir_q.f7b5);
        alu_src_c = 1'b0;
      end
      OPC_OPIMM: begin
        legal_c  = ir_q.funct3 inside {F3_ADD, F3_AND, F3_OR, F3_SLT};
        alu_op_c = f3_to_alu(ir_q.funct3, 1'b0);
      end
      OPC_LOAD:  legal_c = (ir_q.funct3 == F3_W32);
      OPC_STORE: begin
        legal_c   = (ir_q.funct3 == F3_W32);
        imm_src_c = IMM_S;
      end
      OPC_BRANCH: begin
        legal_c   = ir_q.funct3 inside {F3_BEQ, F3_BNE};
        alu_op_c  = ALU_SUB;
        alu_src_c = 1'b0;
        imm_src_c = IMM_B;
      end
      default: legal_c = 1'b0;
    endcase
  end

  assign is_load_c   = (ir_q.opcode == OPC_LOAD);
  assign is_store_c  = (ir_q.opcode == OPC_STORE);
  assign is_branch_c = (ir_q.opcode == OPC_BRANCH);

  // Next state and control outputs
  always_comb begin
    state_n       = state;
    instr_req     = 1'b0;
    IRwrite       = 1'b0;
    ALUctrl       = ALU_ADD;
    ALUsrc        = 1'b0;
    ImmSrc        = IMM_I;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ResultSrc     = 1'b0;
    RegWrite      = 1'b0;
    PCwrite       = 1'b0;
    PCsrc         = 1'b0;
    set_illegal_c = 1'b0;
    retire_c      = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          IRwrite = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        set_illegal_c = !legal_c;
        state_n       = legal_c ? EXECUTE : HALT;
      end
      EXECUTE: begin
        ALUctrl = alu_op_c;
        ALUsrc  = alu_src_c;
        ImmSrc  = imm_src_c;
        if (is_load_c || is_store_c) begin
          state_n = MEM;
        end else if (is_branch_c) begin
          // EQ is high when operands differ: bne takes on EQ, beq on !EQ
          PCwrite  = 1'b1;
          PCsrc    = (ir_q.funct3 == F3_BNE) ? EQ : !EQ;
          retire_c = 1'b1;
          state_n  = FETCH;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store_c;
        ALUctrl = alu_op_c;
        ALUsrc  = alu_src_c;
        ImmSrc  = imm_src_c;
        if (mem_ack) begin
          if (is_store_c) begin
            PCwrite  = 1'b1;
            retire_c = 1'b1;
            state_n  = FETCH;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_load_c;
        PCwrite   = 1'b1;
        retire_c  = 1'b1;
        state_n   = FETCH;
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // State, IR fields, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ir_q    <= '0;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_n;
      if (IRwrite) ir_q <= ir_t'{f7b5: instr[30], funct3: instr[14:12], opcode: instr[6:0]};
      if (set_illegal_c) illegal <= 1'b1;
      if (retire_c) instret <= instret + DATA_WIDTH'(1);
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the reduced RISC-V CPU: the sequencing side of the ALU interface. It fetches an instruction through a request/valid handshake, decodes it, and drives the ALU operation code, operand selects, memory handshake and register/PC write enables. It consumes the ALU's inequality flag to resolve branches and counts retired instructions. It sits between instruction/data memory ports and the datapath (register file, ALU, PC).

## Interface
- DATA_WIDTH, 32, instruction width and instret counter width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  DATA_WIDTH  instruction word from instruction memory; valid when instr_valid=1.
- instr_valid  in  1  instruction memory response; meaningful only while instr_req=1.
- EQ  in  1  ALU flag: 1 when operands differ, 0 when equal.
- mem_ack  in  1  data memory done; meaningful only while mem_req=1.
- instr_req  out  1  fetch request.
- IRwrite  out  1  latch instr into the datapath IR.
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUsrc  out  1  0: rs2 operand, 1: immediate.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type.
- mem_req  out  1  data memory request.
- mem_we  out  1  1 for store; valid with mem_req.
- ResultSrc  out  1  writeback select: 0 ALU result, 1 load data.
- RegWrite  out  1  register file write enable.
- PCwrite  out  1  PC update enable.
- PCsrc  out  1  0: PC+4, 1: PC+B-immediate; valid with PCwrite.
- illegal  out  1  sticky unsupported-instruction flag.
- instret  out  DATA_WIDTH  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT. State, IR copy, illegal and instret are registered; outputs are decoded from state and IR, with PCsrc depending on EQ in EXECUTE.
- Supported instructions:
  - OP (0110011): funct3 000 with funct7[5]=0 add, funct7[5]=1 sub; 111 and; 110 or; 010 slt.
  - OP-IMM (0010011): 000 addi, 111 andi, 110 ori, 010 slti.
  - LOAD (0000011): funct3 010 lw.
  - STORE (0100011): funct3 010 sw.
  - BRANCH (1100011): funct3 000 beq, 001 bne.
  - Everything else is illegal.
- IDLE: all outputs 0; go to FETCH unconditionally.
- FETCH: instr_req=1. Hold until instr_valid=1, then IRwrite=1 and the internal IR captures instr; go to DECODE.
- DECODE: all enables 0. Legal instruction goes to EXECUTE. Illegal instruction sets illegal=1 and goes to HALT.
- EXECUTE:
  - ALUctrl and ALUsrc are set per instruction.
  - lw/sw: add, ALUsrc=1, ImmSrc 00 for lw, 01 for sw; go to MEM.
  - OP/OP-IMM: go to WB.
  - Branch: sub, ALUsrc=0, ImmSrc=10, PCwrite=1, PCsrc=EQ for bne and !EQ for beq; instret increments; go to FETCH.
- MEM: mem_req=1, mem_we=1 for sw only, address-phase ALU controls held. Hold until mem_ack.
  - lw: go to WB.
  - sw: PCwrite=1, PCsrc=0, instret increments; go to FETCH.
- WB: RegWrite=1, ResultSrc=1 for lw else 0, PCwrite=1, PCsrc=0, instret increments; go to FETCH.
- HALT: all outputs 0 except illegal=1 and instret held. Leaves only by reset.
- instret wraps from all-ones to 0.

## Timing
- Reset asserted: state=IDLE, every output 0, instret=0, illegal=0, all asynchronously.
- First instr_req is 2 cycles after rst deasserts (IDLE, then FETCH).
- With zero-wait memory (instr_valid and mem_ack in the same cycle as the request), cycle counts are:
  - ALU ops: 4 (FETCH, DECODE, EXECUTE, WB).
  - sw: 4.
  - lw: 5.
  - branch: 3.
- Each cycle of wait adds one cycle. Requests stay asserted steadily while waiting.
- instr_valid and mem_ack are ignored outside FETCH and MEM respectively.
- PCwrite, RegWrite and the instret increment are single-cycle pulses, once per instruction.
- Reset mid-instruction aborts it: no PCwrite, RegWrite or instret update after the asynchronous assertion.

## Test plan
- Reset, then supply 0x00500093 (addi x1,x0,5) with instr_valid in the first FETCH cycle -> instr_req high in cycle 2; in EXECUTE ALUctrl=000, ALUsrc=1, ImmSrc=00; WB pulses RegWrite=1 and PCwrite=1 with PCsrc=0; instret=1.
- 0x402081B3 (sub), then 0x002081B3 (add) -> ALUctrl=001 then 000, ALUsrc=0, each instruction 4 cycles, instret=2.
- 0x0000A283 (lw) with mem_ack delayed 3 cycles -> mem_req=1 and mem_we=0 for 4 cycles; WB has ResultSrc=1 and RegWrite=1. 0x0050A223 (sw) -> mem_we=1, RegWrite never set.
- 0x00209463 (bne) with EQ=1 -> PCwrite=1, PCsrc=1 in EXECUTE. Same instruction with EQ=0 -> PCsrc=0. beq (funct3 000) with EQ=0 -> PCsrc=1.
- 0x00000000 -> illegal=1 after DECODE, HALT with all enables 0 and instr_req=0 for 20 cycles; reset clears illegal.
- Assert rst during MEM of lw -> all outputs 0 at once, instret unchanged at 0 from reset; fetch resumes 2 cycles after release.
